// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
//
// Raster timing source for the VGA path.
//
// Counts pixels and lines in the vga_clock domain. From these counts it
// produces:
//   - row, column and display_enable, consumed by the screen drawers;
//   - the hsync and vsync pins;
//   - the line, frame and vblank strobes used by game logic.
//
// Default timing is 640x480 @ 60 Hz at a 25.175 MHz pixel rate.
//
// All outputs are registered. Each one reflects the counter state from the
// previous enabled edge. While pixel_enable is low, every output holds its
// value. That includes the strobes, so consumers must qualify the strobes
// with pixel_enable.
//
// Optional build macro:
//   SYNC_DELAY_EN - hsync, vsync and display_enable pass through an extra
//                   DRAWER_LATENCY-stage shift register (advanced by
//                   pixel_enable). This aligns them with pixel colour
//                   leaving a drawer of that latency. column, row and the
//                   strobes are not delayed.
//
// Ports:
//   vga_clock      in   pixel clock
//   reset          in   asynchronous active-low reset
//   pixel_enable   in   clock enable; counters advance only when 1
//   column         out  current horizontal position (0..H_TOTAL-1)
//   row            out  current vertical position (0..V_TOTAL-1)
//   display_enable out  1 inside the visible area
//   hsync          out  horizontal sync pin
//   vsync          out  vertical sync pin
//   line_start     out  strobe at column 0 of every line
//   frame_start    out  strobe at column 0, row 0
//   vblank_start   out  strobe at column 0, row V_ACTIVE
//   frame_count    out  completed-frame counter (wraps at 16 bits)
// -----------------------------------------------------------------------------

module vga_timing_generator_param_check #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int DRAWER_LATENCY = 2
) (
    input logic vga_clock
);
    localparam bit PARAMS_OK = (H_ACTIVE >= 1) && (H_FRONT >= 1) && (H_SYNC >= 1) &&
                               (H_BACK >= 1) && (V_ACTIVE >= 1) && (V_FRONT >= 1) &&
                               (V_SYNC >= 1) && (V_BACK >= 1) && (DRAWER_LATENCY >= 1);

    // Flag an illegal timing parameter set during simulation.
    always @(posedge vga_clock) begin
        assert (PARAMS_OK)
            else $error("vga_timing_generator: every timing parameter must be >= 1");
    end
endmodule

module vga_timing_generator #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int DRAWER_LATENCY  = 2
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        pixel_enable,
    output int          column,
    output int          row,
    output logic        display_enable,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Every boundary below is at most TOTAL-1, so it fits the counter width.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic          SYNC_IDLE  = SYNC_ACTIVE_LOW;

    // Pin level for a sync signal: the pulse level is the inverse of idle.
    function automatic logic sync_level(input logic pulse);
        if (pulse) begin
            sync_level = ~SYNC_IDLE;
        end else begin
            sync_level = SYNC_IDLE;
        end
    endfunction

    vga_timing_generator_param_check #(
        .H_ACTIVE       (H_ACTIVE),
        .H_FRONT        (H_FRONT),
        .H_SYNC         (H_SYNC),
        .H_BACK         (H_BACK),
        .V_ACTIVE       (V_ACTIVE),
        .V_FRONT        (V_FRONT),
        .V_SYNC         (V_SYNC),
        .V_BACK         (V_BACK),
        .DRAWER_LATENCY (DRAWER_LATENCY)
    ) u_param_check (
        .vga_clock (vga_clock)
    );

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic [15:0]   frame_cnt_r;
    logic [HW-1:0] h_next_s;
    logic [VW-1:0] v_next_s;
    logic [15:0]   frame_next_s;

    logic de_s;
    logic hsync_s;
    logic vsync_s;
    logic line_start_s;
    logic frame_start_s;
    logic vblank_start_s;

    logic de_r;
    logic hsync_r;
    logic vsync_r;

    // Raster stepping: pixel wrap advances the line; line wrap completes a frame.
    always_comb begin
        h_next_s     = h_cnt_r;
        v_next_s     = v_cnt_r;
        frame_next_s = frame_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = {HW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_next_s     = {VW{1'b0}};
                frame_next_s = frame_cnt_r + 16'd1;
            end else begin
                v_next_s     = v_cnt_r + {{(VW-1){1'b0}}, 1'b1};
                frame_next_s = frame_cnt_r;
            end
        end else begin
            h_next_s     = h_cnt_r + {{(HW-1){1'b0}}, 1'b1};
            v_next_s     = v_cnt_r;
            frame_next_s = frame_cnt_r;
        end
    end

    // Decode the current raster position into the values the output stage publishes.
    always_comb begin
        de_s           = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        hsync_s        = sync_level((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
        vsync_s        = sync_level((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
        line_start_s   = (h_cnt_r == {HW{1'b0}});
        frame_start_s  = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
        vblank_start_s = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == V_ACT_END);
    end

    // Raster counters, advanced only on enabled pixel edges.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            h_cnt_r     <= {HW{1'b0}};
            v_cnt_r     <= {VW{1'b0}};
            frame_cnt_r <= 16'd0;
        end else if (pixel_enable) begin
            h_cnt_r     <= h_next_s;
            v_cnt_r     <= v_next_s;
            frame_cnt_r <= frame_next_s;
        end
    end

    // Output stage: publish the state the counters held before this edge.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            column       <= 32'sd0;
            row          <= 32'sd0;
            de_r         <= 1'b0;
            hsync_r      <= SYNC_IDLE;
            vsync_r      <= SYNC_IDLE;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= 16'd0;
        end else if (pixel_enable) begin
            column       <= int'(h_cnt_r);
            row          <= int'(v_cnt_r);
            de_r         <= de_s;
            hsync_r      <= hsync_s;
            vsync_r      <= vsync_s;
            line_start   <= line_start_s;
            frame_start  <= frame_start_s;
            vblank_start <= vblank_start_s;
            frame_count  <= frame_cnt_r;
        end
    end

`ifdef SYNC_DELAY_EN
    logic [DRAWER_LATENCY-1:0] hs_dly_r;
    logic [DRAWER_LATENCY-1:0] vs_dly_r;
    logic [DRAWER_LATENCY-1:0] de_dly_r;

    // Delay line that matches the sync/enable pins to the drawer pipeline depth.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            hs_dly_r <= {DRAWER_LATENCY{SYNC_IDLE}};
            vs_dly_r <= {DRAWER_LATENCY{SYNC_IDLE}};
            de_dly_r <= {DRAWER_LATENCY{1'b0}};
        end else if (pixel_enable) begin
            hs_dly_r[0] <= hsync_r;
            vs_dly_r[0] <= vsync_r;
            de_dly_r[0] <= de_r;
            for (int i = 1; i < DRAWER_LATENCY; i++) begin
                hs_dly_r[i] <= hs_dly_r[i-1];
                vs_dly_r[i] <= vs_dly_r[i-1];
                de_dly_r[i] <= de_dly_r[i-1];
            end
        end
    end

    assign hsync          = hs_dly_r[DRAWER_LATENCY-1];
    assign vsync          = vs_dly_r[DRAWER_LATENCY-1];
    assign display_enable = de_dly_r[DRAWER_LATENCY-1];
`else
    assign hsync          = hsync_r;
    assign vsync          = vsync_r;
    assign display_enable = de_r;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Drives two instances from the same vga_clock/reset/pixel_enable inputs:
//   - u_def: default 640x480 timing;
//   - u_sml: a small raster (32x19, active-high sync), so that several whole
//            frames fit into a short run.
//
// A model predicts every output from the number of enabled edges seen since
// reset, using raster arithmetic. Every cycle, the outputs of both instances
// are compared against this model. Directed literal expectations pin the
// model at key points of the sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_generator;

    typedef struct {
        int col;
        int row;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        bit vb;
        int fc;
    } exp_t;

    logic vga_clock = 1'b0;
    logic reset;
    logic pixel_enable;
    logic chk_en = 1'b0;

    int          d_column, d_row;
    logic        d_de, d_hs, d_vs, d_ls, d_fs, d_vb;
    logic [15:0] d_fc;
    int          s_column, s_row;
    logic        s_de, s_hs, s_vs, s_ls, s_fs, s_vb;
    logic [15:0] s_fc;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    always #5 vga_clock = ~vga_clock;

    vga_timing_generator u_def (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .pixel_enable   (pixel_enable),
        .column         (d_column),
        .row            (d_row),
        .display_enable (d_de),
        .hsync          (d_hs),
        .vsync          (d_vs),
        .line_start     (d_ls),
        .frame_start    (d_fs),
        .vblank_start   (d_vb),
        .frame_count    (d_fc)
    );

    vga_timing_generator #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_LOW(1'b0), .DRAWER_LATENCY(2)
    ) u_sml (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .pixel_enable   (pixel_enable),
        .column         (s_column),
        .row            (s_row),
        .display_enable (s_de),
        .hsync          (s_hs),
        .vsync          (s_vs),
        .line_start     (s_ls),
        .frame_start    (s_fs),
        .vblank_start   (s_vb),
        .frame_count    (s_fc)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs after k enabled edges since reset (k = 0 means reset values).
    function automatic exp_t model(input int k, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vbk, input bit alow);
        exp_t e;
        int ht, vt, p, q;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vbk;
        e.col = 0; e.row = 0; e.de = 1'b0; e.hs = alow; e.vs = alow;
        e.ls = 1'b0; e.fs = 1'b0; e.vb = 1'b0; e.fc = 0;
        if (k > 0) begin
            p     = k - 1;
            e.fc  = (p / (ht * vt)) % 65536;
            q     = p % (ht * vt);
            e.col = q % ht;
            e.row = q / ht;
            e.de  = (e.col < ha) && (e.row < va);
            if (e.col >= ha + hf && e.col < ha + hf + hsw) e.hs = !alow;
            if (e.row >= va + vf && e.row < va + vf + vsw) e.vs = !alow;
            e.ls  = (e.col == 0);
            e.fs  = (e.col == 0) && (e.row == 0);
            e.vb  = (e.col == 0) && (e.row == va);
        end
        return e;
    endfunction

    task automatic cmp_all(input string tag, input exp_t e, input int col, input int rw,
                           input logic de, input logic hs, input logic vs, input logic ls,
                           input logic fs, input logic vb, input logic [15:0] fc);
        chk({tag, ".column"}, col, e.col);
        chk({tag, ".row"}, rw, e.row);
        chk({tag, ".display_enable"}, de, e.de);
        chk({tag, ".hsync"}, hs, e.hs);
        chk({tag, ".vsync"}, vs, e.vs);
        chk({tag, ".line_start"}, ls, e.ls);
        chk({tag, ".frame_start"}, fs, e.fs);
        chk({tag, ".vblank_start"}, vb, e.vb);
        chk({tag, ".frame_count"}, fc, e.fc);
    endtask

    // Count enabled edges since reset.
    always @(posedge vga_clock or negedge reset) begin
        if (!reset) ecount <= 0;
        else if (pixel_enable) ecount <= ecount + 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge vga_clock) begin
        if (chk_en) begin
            cmp_all("def", model(ecount, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1),
                    d_column, d_row, d_de, d_hs, d_vs, d_ls, d_fs, d_vb, d_fc);
            cmp_all("sml", model(ecount, 16, 4, 6, 6, 12, 2, 2, 3, 1'b0),
                    s_column, s_row, s_de, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc);
        end
    end

    int hs_low_cnt = 0;
    int vs_act_cnt = 0;
    int vb_cnt     = 0;

    initial begin
        reset        = 1'b1;
        pixel_enable = 1'b0;
        #3;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge vga_clock);
        reset        = 1'b1;
        pixel_enable = 1'b1;
        @(negedge vga_clock);
        // k = 1: first enabled edge after reset
        chk("k1.def.column", d_column, 0);
        chk("k1.def.row", d_row, 0);
        chk("k1.def.display_enable", d_de, 1);
        chk("k1.def.frame_start", d_fs, 1);
        chk("k1.def.line_start", d_ls, 1);
        chk("k1.def.hsync", d_hs, 1);
        chk("k1.def.vsync", d_vs, 1);
        chk("k1.sml.hsync", s_hs, 0);

        for (int k = 2; k <= 1217; k++) begin
            @(negedge vga_clock);
            if (k <= 800 && d_hs == 1'b0) hs_low_cnt++;
            if (k <= 608 && s_vs == 1'b1) vs_act_cnt++;
            if (k <= 608 && s_vb == 1'b1) vb_cnt++;
            if (k == 640) chk("col639.def.display_enable", d_de, 1);
            if (k == 641) chk("col640.def.display_enable", d_de, 0);
            if (k == 656) chk("col655.def.hsync", d_hs, 1);
            if (k == 657) chk("col656.def.hsync", d_hs, 0);
            if (k == 752) chk("col751.def.hsync", d_hs, 0);
            if (k == 753) chk("col752.def.hsync", d_hs, 1);
            if (k == 801) begin
                chk("line1.def.line_start", d_ls, 1);
                chk("line1.def.column", d_column, 0);
                chk("line1.def.row", d_row, 1);
            end
        end
        chk("def.hsync_low_cycles", hs_low_cnt, 96);
        chk("sml.vsync_active_cycles", vs_act_cnt, 64);
        chk("sml.vblank_start_count", vb_cnt, 1);
        chk("frame2.sml.frame_count", s_fc, 2);
        chk("frame2.sml.frame_start", s_fs, 1);
        chk("frame2.def.frame_count", d_fc, 0);

        // Half-rate pixel_enable for two small frames
        for (int i = 0; i < 1216; i++) begin
            pixel_enable = 1'b0;
            @(negedge vga_clock);
            pixel_enable = 1'b1;
            @(negedge vga_clock);
        end
        chk("toggle.sml.frame_count", s_fc, 4);
        chk("toggle.sml.frame_start", s_fs, 1);
        chk("toggle.def.column", d_column, 32);
        chk("toggle.def.row", d_row, 3);

        repeat (268) @(negedge vga_clock);
        chk("mid.def.column", d_column, 300);
        chk("mid.sml.column", s_column, 12);
        chk("mid.sml.row", s_row, 8);

        // Asynchronous reset in the middle of a line
        #2;
        reset = 1'b0;
        #1;
        chk("rst.def.column", d_column, 0);
        chk("rst.def.row", d_row, 0);
        chk("rst.def.display_enable", d_de, 0);
        chk("rst.def.hsync", d_hs, 1);
        chk("rst.def.vsync", d_vs, 1);
        chk("rst.def.line_start", d_ls, 0);
        chk("rst.def.frame_start", d_fs, 0);
        chk("rst.sml.frame_count", s_fc, 0);
        chk("rst.sml.hsync", s_hs, 0);
        repeat (3) @(negedge vga_clock);
        reset        = 1'b1;
        pixel_enable = 1'b0;
        @(negedge vga_clock);
        chk("hold.def.display_enable", d_de, 0);
        pixel_enable = 1'b1;
        repeat (40) @(negedge vga_clock);
        chk("restart.def.column", d_column, 39);
        chk("restart.def.display_enable", d_de, 1);
        chk("restart.sml.column", s_column, 7);
        chk("restart.sml.row", s_row, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
